// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scan-code constants.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Identity of a held key: extended prefix plus scan code.
    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the PS/2 pins, deglitches ps2_clk and emits a falling-edge pulse.
// Latency: 2 sync + FILTER_LEN filter + 1 cycle. No backpressure: edges are never stalled.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [CW-1:0] flt_cnt;
    logic          clk_flt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            flt_cnt  <= '0;
            clk_flt  <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_fall <= 1'b0;
            // Any sample agreeing with the filtered level restarts the run.
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
                clk_flt  <= clk_sync[1];
                flt_cnt  <= '0;
                clk_fall <= clk_flt;
            end else begin
                flt_cnt <= flt_cnt + CW'(1);
            end
        end
    end

    assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decode; KEY_HOLD_EN makes key_en a held level.
// Latency: outputs update one cycle after the filtered STOP falling edge.
// No backpressure: events are single-cycle pulses and must be consumed when presented.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       key_en,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_fall;
    logic          data_s;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          ext_flag;
    logic          brk_flag;
    logic          frame_ok;
`ifdef KEY_HOLD_EN
    key_id_t       held;
`endif

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (clk_fall),
        .data_sync (data_s)
    );

    assign frame_ok = data_s && odd_parity_ok(shift, par_bit);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_in    <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            key_valid <= 1'b0;
            key_en    <= 1'b0;
            frame_err <= 1'b0;
`ifdef KEY_HOLD_EN
            held      <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
`ifndef KEY_HOLD_EN
            key_en    <= 1'b0;
`endif
            // A stalled frame is abandoned but pending prefixes survive.
            if (state != IDLE && !clk_fall) begin
                if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end

            if (clk_fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                            ext_flag  <= 1'b0;
                            brk_flag  <= 1'b0;
                        end else if (shift == PS2_EXT) begin
                            ext_flag <= 1'b1;
                        end else if (shift == PS2_BRK) begin
                            brk_flag <= 1'b1;
                        end else begin
                            key_in    <= shift;
                            key_ext   <= ext_flag;
                            key_break <= brk_flag;
                            key_valid <= 1'b1;
                            ext_flag  <= 1'b0;
                            brk_flag  <= 1'b0;
`ifdef KEY_HOLD_EN
                            if (!brk_flag) begin
                                key_en <= 1'b1;
                                held   <= {ext_flag, shift};
                            end else if (key_en && held == {ext_flag, shift}) begin
                                key_en <= 1'b0;
                            end
`else
                            key_en <= !brk_flag;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
